// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting behind pc_control_unit. It takes the PC, issues one
// read at a time to a synchronous instruction memory, and hands the returned
// word downstream over a valid/ready handshake. A redirect in WAIT or HOLD
// throws the fetched word away and refetches from the new PC. EndFlag on an
// accepted instruction parks the unit in HALT until start drops.
//
// Optional feature: define IFU_PERF_CNT_EN to build the saturating
// fetch/stall performance counters. Without it both counters read 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        fetch enable
//   PC           fetch address (pc_control_unit.PCNext)
//   redirect     non-sequential PC change, flushes WAIT/HOLD
//   EndFlag      program end marker
//   imem_req     one-cycle memory read strobe
//   imem_addr    word-aligned read address (0 when not requesting)
//   imem_rdata   read data, valid the cycle after imem_req
//   Instr        fetched instruction
//   instr_pc     address Instr was read from
//   instr_valid  Instr valid
//   instr_ready  downstream accept
//   fetch_err    sticky misaligned-PC flag
//   fetch_count  accepted-instruction counter
//   stall_count  backpressure-cycle counter
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] PC,
    input  logic              redirect,
    input  logic              EndFlag,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] aligned_pc;
    logic [ADDR_W-1:0] req_pc;

    assign aligned_pc = {PC[ADDR_W-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // The address has already been taken from PC; redirect is
                // irrelevant here.
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_next = S_FETCH;
                end else if (instr_ready) begin
                    if (EndFlag) begin
                        state_next = S_HALT;
                    end else if (start) begin
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Memory request outputs (decoded from state)
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        if (state == S_FETCH) begin
            imem_req  = 1'b1;
            imem_addr = aligned_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pc      <= '0;
            Instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            // instr_valid is high exactly while the FSM sits in HOLD.
            instr_valid <= (state_next == S_HOLD);
            if (state == S_FETCH) begin
                req_pc <= aligned_pc;
                if (PC[1:0] != 2'b00) begin
                    fetch_err <= 1'b1;
                end
            end
            if ((state == S_WAIT) && !redirect) begin
                Instr    <= imem_rdata;
                instr_pc <= req_pc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef IFU_PERF_CNT_EN
    logic handshake;
    logic stall;

    assign handshake = instr_valid & instr_ready;
    assign stall     = (state == S_HOLD) & ~instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (handshake && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit: a vector table for basic fetch + backpressure,
// hand-written sequences for redirect, halt, misalignment and reset, then a
// randomized run checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] PC;
    logic        redirect;
    logic        EndFlag;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .PC          (PC),
        .redirect    (redirect),
        .EndFlag     (EndFlag),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    typedef struct {
        logic        start;
        logic [31:0] pc;
        logic        redirect;
        logic        endf;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] fc;
        logic [31:0] sc;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Counters only exist with the perf feature built in.
    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef IFU_PERF_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    // Memory contents: a fixed arithmetic function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h0123_4567;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] p, input logic r,
                         input logic e, input logic rd, input logic [31:0] d);
        start = s; PC = p; redirect = r; EndFlag = e; instr_ready = rd; imem_rdata = d;
    endtask

    // Random-phase reference model state
    logic        m_req, m_wait, m_valid, m_halt, m_err;
    logic [31:0] m_lat, m_instr, m_pc, m_fc, m_sc, mem_next;

    initial begin
        vt[0] = '{1, 32'h4, 0, 0, 1, 32'h0BAD0BAD, 0, 32'h0, 0, 32'h0,        32'h0, 0, 0};
        vt[1] = '{1, 32'h4, 0, 0, 1, 32'h0BAD0BAD, 1, 32'h4, 0, 32'h0,        32'h0, 0, 0};
        vt[2] = '{1, 32'h4, 0, 0, 0, 32'h65000007, 0, 32'h0, 0, 32'h0,        32'h0, 0, 0};
        vt[3] = '{1, 32'h4, 0, 0, 0, 32'h0BAD0BAD, 0, 32'h0, 1, 32'h65000007, 32'h4, 0, 0};
        vt[4] = '{1, 32'h4, 0, 0, 0, 32'h0BAD0BAD, 0, 32'h0, 1, 32'h65000007, 32'h4, 0, 1};
        vt[5] = '{1, 32'h4, 0, 0, 0, 32'h0BAD0BAD, 0, 32'h0, 1, 32'h65000007, 32'h4, 0, 2};
        vt[6] = '{1, 32'h4, 0, 0, 0, 32'h0BAD0BAD, 0, 32'h0, 1, 32'h65000007, 32'h4, 0, 3};
        vt[7] = '{0, 32'h4, 0, 0, 1, 32'h0BAD0BAD, 0, 32'h0, 1, 32'h65000007, 32'h4, 0, 4};
        vt[8] = '{0, 32'h4, 0, 0, 1, 32'h0BAD0BAD, 0, 32'h0, 0, 32'h65000007, 32'h4, 1, 4};

        // ---------------- Reset with start asserted ----------------
        reset = 1'b0;
        drive(1, 32'h4, 0, 0, 1, 32'hFFFF_FFFF);
        step();
        step();
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_instr", Instr,                32'd0);
        chk("rst_ipc",   instr_pc,             32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err",   {31'd0, fetch_err},   32'd0);
        chk("rst_fc",    fetch_count,          32'd0);
        chk("rst_sc",    stall_count,          32'd0);
        step();
        drive(0, 32'h4, 0, 0, 1, 32'h0);
        reset = 1'b1;
        step();

        // ---------------- Table: basic fetch + backpressure ----------------
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].start, vt[i].pc, vt[i].redirect, vt[i].endf, vt[i].ready, vt[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, vt[i].req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            vt[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].valid});
            if (vt[i].valid) begin
                chk($sformatf("v%0d_instr", i), Instr,    vt[i].instr);
                chk($sformatf("v%0d_ipc", i),   instr_pc, vt[i].ipc);
            end
            chk($sformatf("v%0d_fc", i), fetch_count, cexp(vt[i].fc));
            chk($sformatf("v%0d_sc", i), stall_count, cexp(vt[i].sc));
            step();
        end

        // ---------------- Redirect in WAIT, then EndFlag -> HALT ----------------
        drive(1, 32'h8, 0, 0, 1, 32'h0);
        @(negedge clk); chk("rd_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        @(negedge clk); chk("rd_fetch_addr", imem_addr, 32'h8);
        step();
        drive(1, 32'h50, 1, 0, 1, 32'h1111_1111);
        @(negedge clk); chk("rd_wait_valid", {31'd0, instr_valid}, 32'd0);
        step();
        drive(1, 32'h50, 0, 0, 1, 32'h0);
        @(negedge clk);
        chk("rd_refetch_req",   {31'd0, imem_req},    32'd1);
        chk("rd_refetch_addr",  imem_addr,            32'h50);
        chk("rd_refetch_valid", {31'd0, instr_valid}, 32'd0);
        step();
        drive(1, 32'h50, 0, 0, 1, 32'hC000_0050);
        @(negedge clk); chk("rd_wait2_valid", {31'd0, instr_valid}, 32'd0);
        step();
        drive(1, 32'h50, 0, 1, 1, 32'h0);
        @(negedge clk);
        chk("rd_hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_hold_instr", Instr,                32'hC000_0050);
        chk("rd_hold_ipc",   instr_pc,             32'h50);
        step();
        drive(1, 32'h50, 0, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_req", i),   {31'd0, imem_req},    32'd0);
            chk($sformatf("halt%0d_valid", i), {31'd0, instr_valid}, 32'd0);
            step();
        end
        chk("halt_fc", fetch_count, cexp(32'd2));
        start = 1'b0;
        @(negedge clk); chk("halt_exit_req", {31'd0, imem_req}, 32'd0);
        step();
        // Now IDLE: start must produce a request one cycle later.
        PC = 32'h13E;
        start = 1'b1;
        begin
            int waited = 0;
            while (!imem_req && waited < 4) begin
                step();
                waited++;
            end
            chk("resume_latency", waited, 1);
        end

        // ---------------- Misaligned PC (currently in FETCH) ----------------
        @(negedge clk); chk("mis_addr", imem_addr, 32'h13C);
        step();
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); chk("mis_err", {31'd0, fetch_err}, 32'd1);
        step();
        PC = 32'h20;
        @(negedge clk); chk("mis_ipc", instr_pc, 32'h13C);
        step();
        @(negedge clk); chk("mis_next_addr", imem_addr, 32'h20);
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        chk("mis_sticky_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_sticky_err",   {31'd0, fetch_err},   32'd1);
        step();

        // ---------------- Reset in the middle of a fetch ----------------
        start = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_err",   {31'd0, fetch_err},   32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_fc",    fetch_count,          32'd0);
        start = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_valid", i), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("postrst%0d_req", i),   {31'd0, imem_req},    32'd0);
            step();
        end

        // ---------------- Randomized run against reference model ----------------
        m_req = 0; m_wait = 0; m_valid = 0; m_halt = 0; m_err = 0;
        m_lat = 0; m_instr = 0; m_pc = 0; m_fc = 0; m_sc = 0; mem_next = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic n_req, n_wait, n_valid, n_halt;
            start       = ($urandom_range(7) != 0);
            PC          = $urandom & 32'h0000_0FFF;
            if ($urandom_range(3) != 0) PC[1:0] = 2'b00;
            redirect    = ($urandom_range(5) == 0);
            EndFlag     = ($urandom_range(9) == 0);
            instr_ready = $urandom_range(1) == 1;
            imem_rdata  = mem_next;
            @(negedge clk);
            chk("rnd_req",   {31'd0, imem_req}, {31'd0, m_req});
            chk("rnd_addr",  imem_addr, m_req ? {PC[31:2], 2'b00} : 32'd0);
            chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("rnd_instr", Instr,    m_instr);
                chk("rnd_ipc",   instr_pc, m_pc);
            end
            chk("rnd_err", {31'd0, fetch_err}, {31'd0, m_err});
            chk("rnd_fc",  fetch_count, cexp(m_fc));
            chk("rnd_sc",  stall_count, cexp(m_sc));

            mem_next = imem_req ? mem_word(imem_addr) : $urandom;

            n_req = 0; n_wait = 0; n_valid = m_valid; n_halt = m_halt;
            if (m_req) begin
                n_wait = 1;
                m_lat  = {PC[31:2], 2'b00};
                if (PC[1:0] != 2'b00) m_err = 1;
            end else if (m_wait) begin
                if (redirect) begin
                    n_req = 1;
                end else begin
                    n_valid = 1;
                    m_instr = mem_word(m_lat);
                    m_pc    = m_lat;
                end
            end else if (m_valid) begin
                if (instr_ready) m_fc++;
                else             m_sc++;
                if (redirect) begin
                    n_valid = 0;
                    n_req   = 1;
                end else if (instr_ready) begin
                    n_valid = 0;
                    if (EndFlag)    n_halt = 1;
                    else if (start) n_req  = 1;
                end
            end else if (m_halt) begin
                if (!start) n_halt = 0;
            end else if (start) begin
                n_req = 1;
            end
            m_req = n_req; m_wait = n_wait; m_valid = n_valid; m_halt = n_halt;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that consumes the program counter produced by `pc_control_unit` (`PCNext`), reads the instruction word from a synchronous instruction memory and delivers it downstream with a valid/ready handshake. It is the consumer end of the PC interface: `pc_control_unit` decides *where* to fetch, and this block performs the fetch. It also supplies the `Instr` bus whose fields (`Id`, `Imm`) feed back into `pc_control_unit`. It supports one outstanding memory request, drops the in-flight word on jumps, and halts on `EndFlag`.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction width

- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  fetch enable
- `PC`  in  ADDR_W  fetch address from `pc_control_unit.PCNext`
- `redirect`  in  1  non-sequential PC change (taken JMP/JEQ/JLT); flushes
- `EndFlag`  in  1  program end from `pc_control_unit`
- `imem_req`  out  1  memory read strobe
- `imem_addr`  out  ADDR_W  word-aligned read address
- `imem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `imem_req`
- `Instr`  out  DATA_W  fetched instruction
- `instr_pc`  out  ADDR_W  address `Instr` came from
- `instr_valid`  out  1  `Instr` valid
- `instr_ready`  in  1  downstream accepts when high with `instr_valid`
- `fetch_err`  out  1  sticky misaligned-PC flag
- `fetch_count`  out  32  accepted-instruction counter (see Configuration)
- `stall_count`  out  32  backpressure-cycle counter (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALT.
- IDLE: `imem_req`=0. If `start`=1, go to FETCH.
- FETCH: `imem_req`=1. `imem_addr`={PC[ADDR_W-1:2],2'b00}. Latch `req_pc`=`imem_addr`. Go to WAIT.
- WAIT: if `redirect`=1, discard the data and go to FETCH. Otherwise register `Instr`←`imem_rdata`, `instr_pc`←`req_pc`, `instr_valid`←1, and go to HOLD.
- HOLD: `Instr` and `instr_pc` are held stable. Transitions are evaluated in priority order:
  - `redirect`=1: clear `instr_valid`, go to FETCH (a handshake in the same cycle is still counted as accepted).
  - `instr_ready`=1 and `EndFlag`=1: go to HALT.
  - `instr_ready`=1 and `start`=1: go to FETCH.
  - `instr_ready`=1 and `start`=0: go to IDLE.
  - Otherwise stay in HOLD.
  - `instr_valid` clears when leaving HOLD.
- HALT: `imem_req`=0, `instr_valid`=0. Leave to IDLE only when `start`=0.
- `start` falling mid-fetch: the current fetch completes; the block returns to IDLE after acceptance.
- In FETCH, PC[1:0]≠0 sets `fetch_err`. It clears only on reset; the fetch still proceeds at the aligned address.

## Timing
- Reset (async, `reset`=0): state=IDLE. All outputs are 0: `imem_req`, `imem_addr`, `Instr`, `instr_pc`, `instr_valid`, `fetch_err`, both counters.
- Reset mid-operation: the in-flight response is ignored; no valid is produced after reset releases.
- `start` sampled at edge k ⇒ `imem_req` high in cycle k+1 ⇒ `instr_valid` high after edge k+2.
- Throughput: 3 cycles per instruction with `instr_ready` tied high.
- `imem_req` is high for exactly one cycle per fetch. There is never more than one outstanding request.
- `redirect` in FETCH has no effect: the address was already taken from the current PC. In WAIT and HOLD it flushes.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - `fetch_count` increments on each `instr_valid & instr_ready`.
  - `stall_count` increments each HOLD cycle with `instr_ready`=0.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Not defined: both outputs are tied to 0 and no counter flops are synthesized.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `start`=1 → all outputs 0, no `imem_req`.
- Basic fetch: `start`=1, PC=0x4, memory returns 0x65000007 → single `imem_req` with `imem_addr`=0x4. Two edges later, `instr_valid`=1, `Instr`=0x65000007, `instr_pc`=0x4.
- Backpressure: `instr_ready`=0 for 4 cycles in HOLD → `Instr` stable, `imem_req`=0 throughout, `stall_count`=4 with `IFU_PERF_CNT_EN`. After the ready handshake, `fetch_count`=1.
- Redirect: `redirect`=1 in WAIT while fetching 0x8, PC=0x50 (word 0xC0000050) → old data dropped, no valid for 0x8, next `imem_addr`=0x50.
- End: accept instruction with `EndFlag`=1 → HALT. No `imem_req` for 10 cycles with `start`=1. Then `start`=0 → IDLE, and `start`=1 → fetch resumes.
- Misaligned: PC=0x13E → `imem_addr`=0x13C, `fetch_err`=1. It stays 1 after later aligned fetches until `reset`=0.
